// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side bus bundle for ahb_sram_slave.
interface ahb_sram_slave_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
      input  HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
      output HWDATA,
      input  HREADY, HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with pipelined zero-wait access and two-cycle ERROR response.
// Define AHB_SRAM_WAIT_EN to insert WAIT_STATES wait cycles before every OKAY data phase.
//
// state  | meaning
// S_IDLE | no data phase in progress
// S_WAIT | OKAY data phase stalled, counting down wait cycles
// S_DATA | data phase completing (OKAY, or second ERROR cycle when err_q)
// S_ERR1 | first ERROR cycle, HREADYOUT low
module ahb_sram_slave #(
   parameter int MEM_WORDS   = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic             clk,
   input  logic             reset,
   ahb_sram_slave_if.slave  bus
);

   localparam int AW = $clog2(MEM_WORDS);
`ifdef AHB_SRAM_WAIT_EN
   localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);
`else
   localparam logic [3:0] WAIT_CNT = 4'd0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1} state_t;

   state_t        state_q, state_d;
   logic [31:0]   addr_q;
   logic          write_q;
   logic [2:0]    size_q;
   logic          err_q;
   logic [31:0]   mem [MEM_WORDS];

   logic          capture;
   logic          addr_err;
   logic          mem_we;
   logic [3:0]    be;
   logic [AW-1:0] idx;
   logic          ready;
   logic          resp;
   logic [31:0]   rdata;

   assign idx = addr_q[AW+1:2];

   assign capture = ((state_q == S_IDLE) || (state_q == S_DATA)) &&
                    bus.HSEL && bus.HTRANS[1] && bus.HREADY;

   assign addr_err = (bus.HSIZE > 3'd2) ||
                     ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
                     ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00)) ||
                     ({2'b00, bus.HADDR[31:2]} >= 32'(MEM_WORDS));

`ifdef AHB_SRAM_WAIT_EN
   logic [3:0] wait_cnt_q;

   always_ff @(posedge clk) begin
      if (reset)
         wait_cnt_q <= 4'd0;
      else if (capture && !addr_err)
         wait_cnt_q <= WAIT_CNT;
      else if (state_q == S_WAIT)
         wait_cnt_q <= wait_cnt_q - 4'd1;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= 32'h0;
         write_q <= 1'b0;
         size_q  <= 3'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            addr_q  <= bus.HADDR;
            write_q <= bus.HWRITE;
            size_q  <= bus.HSIZE;
            err_q   <= addr_err;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ready   = 1'b1;
      resp    = 1'b0;
      rdata   = 32'h0;
      mem_we  = 1'b0;
      case (state_q)
         S_IDLE, S_DATA: begin
            if (state_q == S_DATA) begin
               if (err_q)
                  resp = 1'b1;
               else if (write_q)
                  mem_we = 1'b1;
               else
                  rdata = mem[idx];
            end
            if (!capture)
               state_d = S_IDLE;
            else if (addr_err)
               state_d = S_ERR1;
            else if (WAIT_CNT != 4'd0)
               state_d = S_WAIT;
            else
               state_d = S_DATA;
         end
         S_WAIT: begin
            ready = 1'b0;
`ifdef AHB_SRAM_WAIT_EN
            if (wait_cnt_q == 4'd1)
               state_d = S_DATA;
`else
            state_d = S_IDLE;
`endif
         end
         S_ERR1: begin
            ready   = 1'b0;
            resp    = 1'b1;
            state_d = S_DATA;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Misaligned sizes never reach an OKAY data phase, so only aligned lane patterns matter.
   always_comb begin
      case (size_q[1:0])
         2'd0:    be = 4'b0001 << addr_q[1:0];
         2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b])
               mem[idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
         end
      end
   end

   assign bus.HREADYOUT = ready;
   assign bus.HRESP     = resp;
   assign bus.HRDATA    = rdata;

   logic unused_ok;
   assign unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, addr_q[31:AW+2],
                        size_q[2], 4'(WAIT_STATES)};

endmodule
